// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic_sched slice: mode encodings, scheduler states
// and the tag-width helpers used to size the in-flight tag line.
package cordic_pkg;

    localparam int W_DEF = 16;

    localparam logic MODE_ROT = 1'b1;
    localparam logic MODE_VEC = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A tag is {valid, requester index}
    function automatic int tag_width(input int n);
        return idx_width(n) + 1;
    endfunction

endpackage

// File: rtl/cordic_tag_line.sv
// LAT-deep shift register carrying {valid,index} tags alongside the cordic core,
// with an occupancy counter so the scheduler knows when the core has drained.
module cordic_tag_line #(
    parameter int LAT = 16,
    parameter int TW  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-2:0] out_idx,
    output logic          empty
);

    localparam int CW = $clog2(LAT + 2);

    logic [TW-1:0] line [LAT];
    logic [CW-1:0] occ;
    logic          in_valid;

    assign in_valid = in_tag[TW-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                line[i] <= '0;
            end
            occ <= '0;
        end else begin
            line[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                line[i] <= line[i-1];
            end
            case ({in_valid, out_valid})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign out_valid = line[LAT-1][TW-1];
    assign out_idx   = line[LAT-1][TW-2:0];
    assign empty     = (occ == '0);

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined cordic core among NREQ requesters.
// Define CORDIC_SCHED_PRIO_EN to give requester 0 strict priority over the rr pointer.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF,
    parameter int LAT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ*W-1:0] req_z,
    output logic              core_mode,
    output logic [W-1:0]      core_x,
    output logic [W-1:0]      core_y,
    output logic [W-1:0]      core_z,
    input  logic [W-1:0]      core_res1,
    input  logic [W-1:0]      core_res2,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_res1,
    output logic [W-1:0]      resp_res2,
    output logic              busy
);

    localparam int IW = idx_width(NREQ);
    localparam int TW = tag_width(NREQ);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cand_idx;
    logic [IW-1:0]   scan_idx;
    logic            cand_found;
    logic            can_issue;
    logic            grant;
    logic            issue_valid;
    logic [IW-1:0]   issue_idx;
    logic            line_valid;
    logic [IW-1:0]   line_idx;
    logic            line_empty;
    logic            all_empty;

    // Scan downwards so the last hit is the first valid requester at or after ptr
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = IW'((int'(ptr) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
`ifdef CORDIC_SCHED_PRIO_EN
        if (req_valid[0]) begin
            cand_found = 1'b1;
            cand_idx   = '0;
        end
`endif
    end

    always_comb begin
        can_issue = (state == ST_IDLE) || (state == ST_RUN);
`ifdef CORDIC_SCHED_PRIO_EN
        if ((state == ST_DRAIN) && req_valid[0]) begin
            can_issue = 1'b1;
        end
`endif
        grant     = can_issue && cand_found && (req_mode[cand_idx] == core_mode);
        req_ready = grant ? (NREQ'(1) << cand_idx) : '0;
    end

    // The issue tag is registered with the core operands so it lines up with them
    assign all_empty = line_empty && !issue_valid;
    assign busy      = (state != ST_IDLE) || !all_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            core_mode   <= MODE_VEC;
            core_x      <= '0;
            core_y      <= '0;
            core_z      <= '0;
            issue_valid <= 1'b0;
            issue_idx   <= '0;
        end else begin
            issue_valid <= grant;
            issue_idx   <= cand_idx;
            if (grant) begin
                core_x <= req_x[int'(cand_idx)*W +: W];
                core_y <= req_y[int'(cand_idx)*W +: W];
                core_z <= req_z[int'(cand_idx)*W +: W];
                ptr    <= (cand_idx == IW'(NREQ - 1)) ? '0 : cand_idx + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state <= ST_RUN;
                    end else if (cand_found) begin
                        core_mode <= req_mode[cand_idx];
                    end
                end
                ST_RUN: begin
                    if (cand_found && (req_mode[cand_idx] != core_mode)) begin
                        state <= ST_DRAIN;
                    end else if (!grant && all_empty) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (grant) begin
                        state <= ST_RUN;
                    end else if (all_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cordic_tag_line #(
        .LAT (LAT),
        .TW  (TW)
    ) u_tag_line (
        .clk       (clk),
        .reset     (reset),
        .in_tag    ({issue_valid, issue_idx}),
        .out_valid (line_valid),
        .out_idx   (line_idx),
        .empty     (line_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= '0;
            resp_res1  <= '0;
            resp_res2  <= '0;
        end else begin
            resp_valid <= line_valid ? (NREQ'(1) << line_idx) : '0;
            if (line_valid) begin
                resp_res1 <= core_res1;
                resp_res2 <= core_res2;
            end
        end
    end

endmodule
